mcast_bus_tx: RTL
=================

MCAST_BUS_TX -- requirements
Module: mcast_bus_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the payload width.
REQ-002 SHALL have parameter NUM_COL, default 4, meaning the number of caster columns; TAG_W = $clog2(NUM_COL).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the input queue entries (power of 2, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-005 SHALL have ports (name direction width meaning):
  clk  in  1  clock
  rst_n  in  1  async active-low reset
  in_valid  in  1  upstream item valid
  in_ready  out  1  queue can accept an item
  in_data  in  DATA_WIDTH  payload
  in_tag  in  TAG_W  destination tag
  in_bcast  in  1  deliver to all columns, ignoring tag
  cfg_we  in  1  column ID write strobe
  cfg_col  in  TAG_W  column to reconfigure
  cfg_id  in  TAG_W  new ID value
  col_id  out  NUM_COL*TAG_W  per-column ID, drives each caster ID
  data_B2C  out  DATA_WIDTH  shared bus payload to casters
  TAG  out  TAG_W  shared bus tag to casters
  CASTER_EN  out  NUM_COL  per-column enable (offer)
  CASTER_READY  in  NUM_COL  per-column accept
  busy  out  1  high in SEND
  drop_cnt  out  16  count of unmatched items discarded

Function
REQ-006 SHALL push the item {in_data,in_tag,in_bcast} when in_valid && in_ready; in_ready = !full (registered, no pass-through when full).
REQ-007 SHALL compute the head match mask: bit c = in_bcast ? 1 : (col_id[c] == head tag).
REQ-008 SHALL implement FSM IDLE/SEND; reset state IDLE.
REQ-009 IDLE, queue empty: SHALL stay IDLE, CASTER_EN = 0.
REQ-010 IDLE, queue non-empty, mask == 0: SHALL pop head, increment drop_cnt (saturating at 0xFFFF), stay IDLE.
REQ-011 IDLE, queue non-empty, mask != 0: SHALL latch pending = mask, data_B2C = head data, and TAG = head tag, then go to SEND.
REQ-012 SEND: CASTER_EN SHALL equal pending; column c is delivered on a cycle where CASTER_EN[c] && CASTER_READY[c], and pending[c] SHALL clear on the next edge.
REQ-013 SEND: when all remaining pending bits are delivered in the same cycle, the FSM SHALL pop the head and return to IDLE. CASTER_EN SHALL be 0 on the following cycle.
REQ-014 Latency: an item pushed in cycle t onto an empty, idle queue SHALL drive CASTER_EN in cycle t+2. Peak throughput SHALL be one item per 2 cycles.
REQ-015 data_B2C and TAG SHALL hold their last latched values in IDLE.
REQ-016 No timeout: SEND SHALL wait indefinitely for CASTER_READY.
REQ-017 cfg_we SHALL update col_id[cfg_col] on the next edge in any state. An item already in SEND SHALL be unaffected; the new value applies to later mask evaluations.
REQ-018 A simultaneous push and pop SHALL leave the occupancy unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-019 While rst_n is low, the block SHALL, asynchronously:
  - set state to IDLE and empty the queue
  - set CASTER_EN, pending, data_B2C, TAG, busy and drop_cnt to 0
  - set col_id[c] = c
  - set in_ready = 1
REQ-020 A reset during SEND SHALL discard the in-flight item with no further enables.

Structure
REQ-021 Package mcast_pkg SHALL hold the state enum and the TAG_W width function.
REQ-022 Queue storage SHALL be the sub-module mcast_fifo (sync FIFO with full/empty outputs); the FSM and mask logic stay in mcast_bus_tx.

Verification (NUM_COL=4, FIFO_DEPTH=4, IDs after reset 0..3)
REQ-023 Unicast: push data 0x1234, tag 2; expected:
  - cycle t+2: CASTER_EN=0100, data_B2C=0x1234, TAG=2
  - READY[2]=1 that cycle: next cycle CASTER_EN=0000, busy=0
REQ-024 Multicast: cfg col1 and col3 to ID 2, then push tag 2; expected:
  - CASTER_EN=1110
  - READY[3] one cycle -> 0110
  - READY[1] -> 0100
  - READY[2] -> 0000 and pop
REQ-025 Broadcast stall: push bcast=1 with READY=1110 held; expected:
  - CASTER_EN becomes 0001 and holds 10 cycles until READY[0]=1
  - then 0000
REQ-026 Drop: set all IDs to 0, push tag 3; expected:
  - no CASTER_EN ever
  - drop_cnt=1 two cycles after push
  - queue empty
REQ-027 Full: READY=0000, push 5 items back-to-back; expected:
  - in_ready low after the 4th accept
  - 5th item held until the first delivery completes, then accepted
REQ-028 Reset mid-SEND: CASTER_EN=0100, assert rst_n=0 mid-cycle; expected:
  - CASTER_EN=0 immediately
  - after release: in_ready=1, drop_cnt=0, col_id={3,2,1,0}

Source files
------------

// File: rtl/mcast_pkg.sv
// ---------------------------------------------------------------------------
// mcast_pkg
// Shared definitions for the multicast bus transmitter:
//   state_t    - transmitter FSM states (IDLE / SEND)
//   tag_width  - width of a column tag / column ID for a given column count
// ---------------------------------------------------------------------------
package mcast_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // A single column still needs a 1-bit tag so every port keeps a legal width.
   function automatic int tag_width(input int num_col);
      return (num_col > 1) ? $clog2(num_col) : 1;
   endfunction

endpackage

// File: rtl/mcast_fifo.sv
// ---------------------------------------------------------------------------
// mcast_fifo
// Synchronous show-ahead FIFO. The head entry is visible on rdata whenever
// empty is low; pop removes it on the next edge. full/empty are registered.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the queue)
//   push, wdata    write strobe and data (ignored while full)
//   pop            remove head (ignored while empty)
//   rdata          head entry
//   full, empty    occupancy flags
// ---------------------------------------------------------------------------
module mcast_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
   localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic [AW:0]      count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign push_ok_s = push && !full_r;
   assign pop_ok_s  = pop && !empty_r;
   assign rdata     = mem_r[rd_ptr_r];
   assign full      = full_r;
   assign empty     = empty_r;

   // Next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Storage write port; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers (wrap naturally modulo the power-of-two depth) and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= CNT_ZERO;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_DEPTH);
         empty_r <= (count_nxt_s == CNT_ZERO);
      end
   end

endmodule

// File: rtl/mcast_bus_tx.sv
// ---------------------------------------------------------------------------
// mcast_bus_tx
// Multicast bus transmitter. Items are queued, then offered on a shared bus
// to every caster column whose ID matches the item tag (or to all columns
// for broadcast). The item stays on the bus until every selected column has
// accepted it; items matching no column are discarded and counted.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_data/in_tag/in_bcast item
//   cfg_we/cfg_col/cfg_id  column ID reconfiguration
//   col_id              per-column IDs, column c at [c*TAG_W +: TAG_W]
//   data_B2C, TAG       shared bus payload and tag
//   CASTER_EN           per-column offer; CASTER_READY per-column accept
//   busy                high while an item is being delivered
//   drop_cnt            saturating count of discarded items
// ---------------------------------------------------------------------------
module mcast_bus_tx
   import mcast_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int TAG_W     = tag_width(NUM_COL)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic [TAG_W-1:0]         in_tag,
   input  logic                     in_bcast,
   input  logic                     cfg_we,
   input  logic [TAG_W-1:0]         cfg_col,
   input  logic [TAG_W-1:0]         cfg_id,
   output logic [NUM_COL*TAG_W-1:0] col_id,
   output logic [DATA_WIDTH-1:0]    data_B2C,
   output logic [TAG_W-1:0]         TAG,
   output logic [NUM_COL-1:0]       CASTER_EN,
   input  logic [NUM_COL-1:0]       CASTER_READY,
   output logic                     busy,
   output logic [15:0]              drop_cnt
);

   localparam int ITEM_W = DATA_WIDTH + TAG_W + 1;

   state_t                state_r;
   logic [NUM_COL-1:0]    pending_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [TAG_W-1:0]      tag_r;
   logic                  busy_r;
   logic [15:0]           drop_r;
   logic [TAG_W-1:0]      col_id_r [NUM_COL];

   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic [ITEM_W-1:0]     head_s;
   logic [DATA_WIDTH-1:0] head_data_s;
   logic [TAG_W-1:0]      head_tag_s;
   logic                  head_bcast_s;
   logic [NUM_COL-1:0]    mask_s;
   logic [NUM_COL-1:0]    left_s;

   // Full blocks a push even when a pop happens in the same cycle.
   assign push_s   = in_valid && !fifo_full_s;
   assign in_ready = !fifo_full_s;

   mcast_fifo #(
      .WIDTH (ITEM_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata ({in_data, in_tag, in_bcast}),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign {head_data_s, head_tag_s, head_bcast_s} = head_s;

   // Head match mask against the current column IDs.
   always_comb begin
      mask_s = {NUM_COL{1'b0}};
      for (int c = 0; c < NUM_COL; c++) begin
         if (head_bcast_s) begin
            mask_s[c] = 1'b1;
         end else if (col_id_r[c] == head_tag_s) begin
            mask_s[c] = 1'b1;
         end else begin
            mask_s[c] = 1'b0;
         end
      end
   end

   // Columns still owed the item after this cycle's accepts, and the pop decision.
   always_comb begin
      left_s = pending_r & ~CASTER_READY;
      pop_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s && (mask_s == {NUM_COL{1'b0}})) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         ST_SEND: begin
            if (left_s == {NUM_COL{1'b0}}) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         default: pop_s = 1'b0;
      endcase
   end

   // Column ID table; a write only affects masks evaluated afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_COL; c++) begin
            col_id_r[c] <= TAG_W'(c);
         end
      end else if (cfg_we && (int'(cfg_col) < NUM_COL)) begin
         col_id_r[cfg_col] <= cfg_id;
      end
   end

   // Transmit FSM. pending_r is nonzero only in SEND and drives CASTER_EN
   // directly, so the enables drop the cycle after the last accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         pending_r <= {NUM_COL{1'b0}};
         data_r    <= {DATA_WIDTH{1'b0}};
         tag_r     <= {TAG_W{1'b0}};
         busy_r    <= 1'b0;
         drop_r    <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  if (mask_s == {NUM_COL{1'b0}}) begin
                     if (drop_r != 16'hFFFF) begin
                        drop_r <= drop_r + 16'h0001;
                     end
                  end else begin
                     pending_r <= mask_s;
                     data_r    <= head_data_s;
                     tag_r     <= head_tag_s;
                     busy_r    <= 1'b1;
                     state_r   <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               pending_r <= left_s;
               if (left_s == {NUM_COL{1'b0}}) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               pending_r <= {NUM_COL{1'b0}};
               busy_r    <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   genvar gc;
   generate
      for (gc = 0; gc < NUM_COL; gc++) begin : g_col_id
         assign col_id[gc*TAG_W +: TAG_W] = col_id_r[gc];
      end
   endgenerate

   assign data_B2C  = data_r;
   assign TAG       = tag_r;
   assign CASTER_EN = pending_r;
   assign busy      = busy_r;
   assign drop_cnt  = drop_r;

endmodule
